// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 response packer and its helpers.
// Holds the FSM state enum, command/response codes and error detail bytes.
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIGGER,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_SEND_CODE,
        ST_SEND_DATA
    } state_e;

    typedef enum logic {
        KIND_TEMP,
        KIND_HUM
    } kind_e;

    typedef struct packed {
        logic [7:0] hum_int;
        logic [7:0] hum_frac;
        logic [7:0] temp_int;
        logic [7:0] temp_frac;
        logic [7:0] par;
    } reading_t;

    localparam logic [7:0] CMD_STATUS    = 8'h00;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_HUM       = 8'h02;
    localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
    localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
    localparam logic [7:0] CMD_STOP_CONT = 8'h05;
    localparam logic [7:0] CMD_ERR_COUNT = 8'h06;

    localparam logic [7:0] RSP_OK      = 8'h07;
    localparam logic [7:0] RSP_HUM     = 8'h08;
    localparam logic [7:0] RSP_TEMP    = 8'h09;
    localparam logic [7:0] RSP_STOP    = 8'h0A;
    localparam logic [7:0] RSP_ERRCNT  = 8'h1E;
    localparam logic [7:0] RSP_ERR     = 8'h1F;
    localparam logic [7:0] RSP_INVALID = 8'hFF;

    localparam logic [7:0] ERR_CHECKSUM = 8'h01;
    localparam logic [7:0] ERR_TIMEOUT  = 8'h02;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dht11_response_packer_if.sv
// Bundle between the packer and its neighbours: UART RX command stream,
// DHT11 reader enable/done/bytes, UART TX byte stream and continuous flag.
// slave: packer side.  master: environment (RX, reader, TX) side.
interface dht11_response_packer_if;

    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    logic       sensor_enable;
    logic       sensor_done;
    logic [7:0] hum_int;
    logic [7:0] hum_frac;
    logic [7:0] temp_int;
    logic [7:0] temp_frac;
    logic [7:0] par;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    logic       cont_active;

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready,
        output sensor_enable,
        input  sensor_done,
        input  hum_int, hum_frac, temp_int, temp_frac, par,
        output tx_valid, tx_data,
        input  tx_ready,
        output cont_active
    );

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready,
        input  sensor_enable,
        output sensor_done,
        output hum_int, hum_frac, temp_int, temp_frac, par,
        input  tx_valid, tx_data,
        output tx_ready,
        input  cont_active
    );

endinterface

// File: rtl/dht11_checksum.sv
// Combinational DHT11 checksum: 8-bit wrapping sum of the four data bytes
// compared to the parity byte.  Ports: four data bytes, par_i in; ok_o out.
module dht11_checksum (
    input  logic [7:0] hum_int_i,
    input  logic [7:0] hum_frac_i,
    input  logic [7:0] temp_int_i,
    input  logic [7:0] temp_frac_i,
    input  logic [7:0] par_i,
    output logic       ok_o
);

    logic [7:0] sum;

    // 8-bit result drops the carries: modulo-256 sum
    assign sum  = hum_int_i + hum_frac_i + temp_int_i + temp_frac_i;
    assign ok_o = (sum == par_i);

endmodule

// File: rtl/dht11_response_packer.sv
// Command-driven DHT11 read sequencer: decodes RX commands, pulses the reader,
// waits for done with timeout, checks parity and sends a 2-byte TX response.
// Ports: clk, rst (async active-low), bus (slave modport of the bundle),
// err_count (only when DHT_ERR_COUNTER_EN is defined; adds command 0x06).
module dht11_response_packer
    import dht11_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned PERIOD_CYCLES  = 100000000
) (
    input  logic                   clk,
    input  logic                   rst,
    dht11_response_packer_if.slave bus
`ifdef DHT_ERR_COUNTER_EN
    ,
    output logic [7:0]             err_count
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d;
    kind_e         cont_kind_q, cont_kind_d;
    logic          cont_q, cont_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] per_q, per_d;
    reading_t      rd_q, rd_d;
    logic [7:0]    code_q, code_d;
    logic [7:0]    data_q, data_d;
    logic          sum_ok;
    logic          accept;
`ifdef DHT_ERR_COUNTER_EN
    logic [7:0]    err_q, err_d;
    assign err_count = err_q;
`endif

    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

    dht11_checksum u_checksum (
        .hum_int_i   (rd_q.hum_int),
        .hum_frac_i  (rd_q.hum_frac),
        .temp_int_i  (rd_q.temp_int),
        .temp_frac_i (rd_q.temp_frac),
        .par_i       (rd_q.par),
        .ok_o        (sum_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_TEMP;
            cont_kind_q <= KIND_TEMP;
            cont_q      <= 1'b0;
            tmo_q       <= '0;
            per_q       <= '0;
            rd_q        <= '0;
            code_q      <= 8'h00;
            data_q      <= 8'h00;
`ifdef DHT_ERR_COUNTER_EN
            err_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cont_kind_q <= cont_kind_d;
            cont_q      <= cont_d;
            tmo_q       <= tmo_d;
            per_q       <= per_d;
            rd_q        <= rd_d;
            code_q      <= code_d;
            data_q      <= data_d;
`ifdef DHT_ERR_COUNTER_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cont_kind_d = cont_kind_q;
        cont_d      = cont_q;
        tmo_d       = tmo_q;
        per_d       = per_q;
        rd_d        = rd_q;
        code_d      = code_q;
        data_d      = data_q;
`ifdef DHT_ERR_COUNTER_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cont_q) per_d = per_q + PW'(1);
                // a command beats a period tick in the same cycle
                if (accept) begin
                    per_d = '0;
                    case (bus.cmd_data)
                        CMD_STATUS: begin
                            code_d  = RSP_OK;
                            data_d  = 8'h00;
                            state_d = ST_SEND_CODE;
                        end
                        CMD_TEMP: begin
                            kind_d  = KIND_TEMP;
                            state_d = ST_TRIGGER;
                        end
                        CMD_HUM: begin
                            kind_d  = KIND_HUM;
                            state_d = ST_TRIGGER;
                        end
                        CMD_CONT_TEMP: begin
                            cont_d      = 1'b1;
                            cont_kind_d = KIND_TEMP;
                            kind_d      = KIND_TEMP;
                            state_d     = ST_TRIGGER;
                        end
                        CMD_CONT_HUM: begin
                            cont_d      = 1'b1;
                            cont_kind_d = KIND_HUM;
                            kind_d      = KIND_HUM;
                            state_d     = ST_TRIGGER;
                        end
                        CMD_STOP_CONT: begin
                            cont_d  = 1'b0;
                            code_d  = RSP_STOP;
                            data_d  = 8'h00;
                            state_d = ST_SEND_CODE;
                        end
`ifdef DHT_ERR_COUNTER_EN
                        CMD_ERR_COUNT: begin
                            code_d  = RSP_ERRCNT;
                            data_d  = err_q;
                            state_d = ST_SEND_CODE;
                        end
`endif
                        default: begin
                            code_d  = RSP_INVALID;
                            data_d  = bus.cmd_data;
                            state_d = ST_SEND_CODE;
                        end
                    endcase
                end else if (cont_q && per_q == PER_LAST) begin
                    per_d   = '0;
                    kind_d  = cont_kind_q;
                    state_d = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                tmo_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // done wins over the timeout on the last cycle
                if (bus.sensor_done) begin
                    rd_d    = '{bus.hum_int, bus.hum_frac,
                                bus.temp_int, bus.temp_frac, bus.par};
                    state_d = ST_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    code_d  = RSP_ERR;
                    data_d  = ERR_TIMEOUT;
                    state_d = ST_SEND_CODE;
`ifdef DHT_ERR_COUNTER_EN
                    err_d   = sat_inc8(err_q);
`endif
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHECK: begin
                if (sum_ok) begin
                    code_d = (kind_q == KIND_TEMP) ? RSP_TEMP : RSP_HUM;
                    data_d = (kind_q == KIND_TEMP) ? rd_q.temp_int
                                                   : rd_q.hum_int;
`ifdef DHT_ERR_COUNTER_EN
                    err_d  = 8'h00;
`endif
                end else begin
                    code_d = RSP_ERR;
                    data_d = ERR_CHECKSUM;
`ifdef DHT_ERR_COUNTER_EN
                    err_d  = sat_inc8(err_q);
`endif
                end
                state_d = ST_SEND_CODE;
            end
            ST_SEND_CODE: begin
                if (bus.tx_ready) state_d = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                if (bus.tx_ready) begin
                    per_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready     = 1'b0;
        bus.sensor_enable = 1'b0;
        bus.tx_valid      = 1'b0;
        bus.tx_data       = 8'h00;
        unique case (state_q)
            ST_IDLE:    bus.cmd_ready = 1'b1;
            ST_TRIGGER: bus.sensor_enable = 1'b1;
            ST_SEND_CODE: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = code_q;
            end
            ST_SEND_DATA: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = data_q;
            end
            default: ;
        endcase
    end

    assign bus.cont_active = cont_q;

endmodule
